rf_wb_arbiter: RTL and testbench

Write-back arbiter and pending-write scoreboard for the 32-entry integer register file. It shares the register file's single write port between the ALU write-back path (port A) and the load-return path (port B). Requests use a valid/ready handshake. A fixed-priority policy favours A, with a starvation guard for B. A per-register busy scoreboard lets decode detect read-after-write hazards on in-flight writes.

---
 rtl/rf_wb_arbiter_if.sv | 61 ++++++
 rtl/rf_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter_if
//  Description : Bundle of the write-back arbiter's request, issue, hazard
//                query and register-file write signals. The slave modport is
//                the arbiter's view; master is the surrounding pipeline's.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if #(
    parameter int N = 32
);
    // ALU write-back request (port A)
    logic         a_valid;
    logic [4:0]   a_rd;
    logic [N-1:0] a_data;
    logic         a_ready;

    // Load-return request (port B)
    logic         b_valid;
    logic [4:0]   b_rd;
    logic [N-1:0] b_data;
    logic         b_ready;

    // Issue notification: a write to iss_rd is now in flight
    logic         iss_valid;
    logic [4:0]   iss_rd;

    // Read-after-write hazard queries from decode
    logic [4:0]   q_rs1;
    logic [4:0]   q_rs2;
    logic         q_busy1;
    logic         q_busy2;

    // Register-file write port
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [N-1:0] rf_wdata;

    modport slave (
        input  a_valid, a_rd, a_data,
        output a_ready,
        input  b_valid, b_rd, b_data,
        output b_ready,
        input  iss_valid, iss_rd,
        input  q_rs1, q_rs2,
        output q_busy1, q_busy2,
        output rf_we, rf_waddr, rf_wdata
    );

    modport master (
        output a_valid, a_rd, a_data,
        input  a_ready,
        output b_valid, b_rd, b_data,
        input  b_ready,
        output iss_valid, iss_rd,
        output q_rs1, q_rs2,
        input  q_busy1, q_busy2,
        input  rf_we, rf_waddr, rf_wdata
    );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter
//  Description : Shares the single register-file write port between the ALU
//                write-back path (A) and the load-return path (B). A has
//                fixed priority; B is forced ahead once it has been refused
//                STARVE_MAX consecutive cycles. A 32-entry busy scoreboard
//                tracks in-flight writes for read-after-write hazard checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int N          = 32,
    parameter int STARVE_MAX = 4
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    rf_wb_arbiter_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STARVE_MAX);
    localparam logic [4:0]       c_X0      = 5'd0;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_starve;     // consecutive cycles B has been refused
    logic               r_rf_we;
    logic [4:0]         r_rf_waddr;
    logic [N-1:0]       r_rf_wdata;
    logic [31:1]        r_busy;       // x0 never has a pending write

    logic               w_force_b;
    logic               w_a_gnt;
    logic               w_b_gnt;
    logic               w_xfer;
    logic [4:0]         w_rd;
    logic [N-1:0]       w_data;
    logic               w_wr;
    logic [31:1]        w_set;
    logic [31:1]        w_clr;
    logic [31:0]        w_busy;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    // B is promoted only once its refusal count has saturated; grants are
    // suppressed while reset is asserted so nothing is accepted into a
    // write register that is being held clear.
    always_comb begin
        w_force_b = bus.b_valid && (r_starve == c_CNT_MAX);
        w_a_gnt   = rst_n && bus.a_valid && !w_force_b;
        w_b_gnt   = rst_n && bus.b_valid && (w_force_b || !bus.a_valid);
    end

    assign bus.a_ready = w_a_gnt;
    assign bus.b_ready = w_b_gnt;

    // Select the winning request's destination and data; a transfer to x0 is
    // accepted but never turns into a register-file write.
    always_comb begin
        w_xfer = w_a_gnt || w_b_gnt;
        w_rd   = w_a_gnt ? bus.a_rd   : bus.b_rd;
        w_data = w_a_gnt ? bus.a_data : bus.b_data;
        w_wr   = w_xfer && (w_rd != c_X0);
    end

    // ------------------------------------------------------------------------
    // Starvation counter
    // ------------------------------------------------------------------------
    // Counts consecutive refusals of a pending B request, saturating at the
    // limit; any B transfer or an idle B restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (bus.b_valid && !w_b_gnt) begin
            if (r_starve != c_CNT_MAX) begin
                r_starve <= r_starve + c_CNT_W'(1);
            end
        end else begin
            r_starve <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Write register
    // ------------------------------------------------------------------------
    // Capture the granted write one cycle after the handshake; rf_we is a
    // single-cycle pulse because it is recomputed from the grant every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_wr;
            if (w_xfer) begin
                r_rf_waddr <= w_rd;
                r_rf_wdata <= w_data;
            end
        end
    end

    assign bus.rf_we    = r_rf_we;
    assign bus.rf_waddr = r_rf_waddr;
    assign bus.rf_wdata = r_rf_wdata;

    // ------------------------------------------------------------------------
    // Busy scoreboard
    // ------------------------------------------------------------------------
    // One flop per architectural register x1..x31. Set has priority over
    // clear: if an issue and a write-back hit the same register in the same
    // cycle, the issue belongs to a newer writer that is still in flight.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            assign w_set[gi] = bus.iss_valid && (bus.iss_rd == 5'(gi));
            assign w_clr[gi] = w_wr && (w_rd == 5'(gi));

            // Per-register pending-write flag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_busy[gi] <= 1'b0;
                end else begin
                    r_busy[gi] <= w_set[gi] || (r_busy[gi] && !w_clr[gi]);
                end
            end
        end
    endgenerate

    // Register 0 reads as never busy, so a query of x0 returns 0 for free.
    assign w_busy = {r_busy, 1'b0};

    // Queries see the registered vector: a write-back clears its bit only
    // from the cycle after the handshake.
    assign bus.q_busy1 = w_busy[bus.q_rs1];
    assign bus.q_busy2 = w_busy[bus.q_rs2];

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wb_arbiter
//  Description : Directed stimulus for rf_wb_arbiter with a cycle-level
//                reference model and literal pinned expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int N          = 32;
    localparam int STARVE_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    rf_wb_arbiter_if #(.N(N)) bus ();

    rf_wb_arbiter #(.N(N), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_refused = 0;
    bit [31:0]   m_busy    = '0;
    bit          m_we      = 1'b0;
    bit [4:0]    m_waddr   = '0;
    bit [N-1:0]  m_wdata   = '0;
    int          n_refused = 0;
    bit [31:0]   n_busy    = '0;
    bit          n_we      = 1'b0;
    bit [4:0]    n_waddr   = '0;
    bit [N-1:0]  n_wdata   = '0;

    // Literal expectations pinned by the stimulus for the current cycle
    bit p_ar_en, p_ar, p_br_en, p_br, p_we_en, p_we;
    bit p_wa_en, p_wd_en, p_q1_en, p_q1, p_q2_en, p_q2;
    bit [4:0]   p_wa;
    bit [N-1:0] p_wd;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs are sampled mid-cycle, inputs are stable then.
    always @(negedge clk) begin
        bit       e_a, e_b, g_any;
        bit [4:0] g_rd;
        bit [N-1:0] g_data;
        bit [31:0] nb;

        // Grant rule: A first, unless B has waited its full allowance.
        e_a = 1'b0;
        e_b = 1'b0;
        if (rst_n) begin
            if (bus.b_valid && m_refused == STARVE_MAX) e_b = 1'b1;
            else if (bus.a_valid)                       e_a = 1'b1;
            else if (bus.b_valid)                       e_b = 1'b1;
        end

        check("a_ready", {31'd0, bus.a_ready}, {31'd0, e_a});
        check("b_ready", {31'd0, bus.b_ready}, {31'd0, e_b});
        check("rf_we",   {31'd0, bus.rf_we},   {31'd0, m_we});
        if (m_we) begin
            check("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, m_waddr});
            check("rf_wdata", bus.rf_wdata, m_wdata);
        end
        check("q_busy1", {31'd0, bus.q_busy1}, {31'd0, (bus.q_rs1 != 0) && m_busy[bus.q_rs1]});
        check("q_busy2", {31'd0, bus.q_busy2}, {31'd0, (bus.q_rs2 != 0) && m_busy[bus.q_rs2]});
        if (!rst_n) begin
            check("rst_waddr", {27'd0, bus.rf_waddr}, '0);
            check("rst_wdata", bus.rf_wdata, '0);
        end

        if (p_ar_en) check("pin_a_ready", {31'd0, bus.a_ready}, {31'd0, p_ar});
        if (p_br_en) check("pin_b_ready", {31'd0, bus.b_ready}, {31'd0, p_br});
        if (p_we_en) check("pin_rf_we", {31'd0, bus.rf_we}, {31'd0, p_we});
        if (p_wa_en) check("pin_rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, p_wa});
        if (p_wd_en) check("pin_rf_wdata", bus.rf_wdata, p_wd);
        if (p_q1_en) check("pin_q_busy1", {31'd0, bus.q_busy1}, {31'd0, p_q1});
        if (p_q2_en) check("pin_q_busy2", {31'd0, bus.q_busy2}, {31'd0, p_q2});

        // Next model state, applied at the coming rising edge
        g_any  = e_a || e_b;
        g_rd   = e_a ? bus.a_rd : bus.b_rd;
        g_data = e_a ? bus.a_data : bus.b_data;
        n_refused = (bus.b_valid && !e_b) ? ((m_refused < STARVE_MAX) ? m_refused + 1 : STARVE_MAX) : 0;
        n_we      = g_any && (g_rd != 0);
        n_waddr   = g_any ? g_rd : m_waddr;
        n_wdata   = g_any ? g_data : m_wdata;
        nb = m_busy;
        if (n_we) nb[g_rd] = 1'b0;
        if (bus.iss_valid && bus.iss_rd != 0) nb[bus.iss_rd] = 1'b1;
        n_busy = nb;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_refused <= 0;
            m_busy    <= '0;
            m_we      <= 1'b0;
            m_waddr   <= '0;
            m_wdata   <= '0;
        end else begin
            m_refused <= n_refused;
            m_busy    <= n_busy;
            m_we      <= n_we;
            m_waddr   <= n_waddr;
            m_wdata   <= n_wdata;
        end
    end

    task automatic clear_pins();
        p_ar_en = 0; p_br_en = 0; p_we_en = 0; p_wa_en = 0;
        p_wd_en = 0; p_q1_en = 0; p_q2_en = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clear_pins();
    endtask

    task automatic idle();
        bus.a_valid = 0; bus.b_valid = 0; bus.iss_valid = 0;
    endtask

    task automatic pin_write(input bit [4:0] wa, input bit [N-1:0] wd);
        p_we_en = 1; p_we = 1; p_wa_en = 1; p_wa = wa; p_wd_en = 1; p_wd = wd;
    endtask

    initial begin
        clear_pins();
        bus.a_valid = 0; bus.a_rd = 0; bus.a_data = '0;
        bus.b_valid = 0; bus.b_rd = 0; bus.b_data = '0;
        bus.iss_valid = 0; bus.iss_rd = 0;
        bus.q_rs1 = 0; bus.q_rs2 = 0;
        #2 rst_n = 0;

        // Requests are ignored while reset is held
        cyc(); bus.a_valid = 1; bus.a_rd = 5'd2; p_ar_en = 1; p_ar = 0;
        p_we_en = 1; p_we = 0;
        cyc(); rst_n = 1; idle();
        bus.q_rs1 = 5; bus.q_rs2 = 0;
        p_q1_en = 1; p_q1 = 0; p_q2_en = 1; p_q2 = 0; p_we_en = 1; p_we = 0;

        // Issue x7, then ALU write-back to x7
        cyc(); bus.iss_valid = 1; bus.iss_rd = 7; bus.q_rs1 = 7; p_q1_en = 1; p_q1 = 0;
        cyc(); bus.iss_valid = 0;
        bus.a_valid = 1; bus.a_rd = 7; bus.a_data = 32'hDEADBEEF;
        p_ar_en = 1; p_ar = 1; p_q1_en = 1; p_q1 = 1;
        cyc(); idle(); pin_write(5'd7, 32'hDEADBEEF); p_q1_en = 1; p_q1 = 0;
        cyc(); p_we_en = 1; p_we = 0;

        // Continuous A and B: four A grants then one forced B, repeating
        bus.a_rd = 9;  bus.a_data = 32'hA5A50009;
        bus.b_rd = 20; bus.b_data = 32'hB0B00014;
        for (int k = 0; k < 15; k++) begin
            cyc();
            bus.a_valid = 1; bus.b_valid = 1;
            p_ar_en = 1; p_ar = (k % 5 != 4);
            p_br_en = 1; p_br = (k % 5 == 4);
            if (k > 0 && k % 5 == 0) pin_write(5'd20, 32'hB0B00014);
        end
        cyc(); idle(); pin_write(5'd20, 32'hB0B00014);

        // Write to x0 is accepted but never writes
        cyc(); bus.a_valid = 1; bus.a_rd = 0; bus.a_data = 32'h1234; bus.q_rs1 = 0;
        p_ar_en = 1; p_ar = 1;
        cyc(); idle(); p_we_en = 1; p_we = 0; p_q1_en = 1; p_q1 = 0;

        // Issue and B write-back to x3 in the same cycle: busy stays set
        cyc(); bus.iss_valid = 1; bus.iss_rd = 3;
        bus.b_valid = 1; bus.b_rd = 3; bus.b_data = 32'h3333; bus.q_rs1 = 3;
        p_br_en = 1; p_br = 1; p_q1_en = 1; p_q1 = 0;
        cyc(); idle(); pin_write(5'd3, 32'h3333); p_q1_en = 1; p_q1 = 1;
        cyc(); bus.a_valid = 1; bus.a_rd = 3; bus.a_data = 32'h3003;
        p_ar_en = 1; p_ar = 1; p_q1_en = 1; p_q1 = 1;
        cyc(); idle(); pin_write(5'd3, 32'h3003); p_q1_en = 1; p_q1 = 0;

        // Mark x8..x11 busy, start a write, then reset mid-flight
        for (int r = 8; r < 12; r++) begin
            cyc(); bus.iss_valid = 1; bus.iss_rd = 5'(r);
        end
        cyc(); bus.iss_valid = 0; bus.q_rs1 = 8; bus.q_rs2 = 11;
        bus.a_valid = 1; bus.a_rd = 5; bus.a_data = 32'h55;
        p_ar_en = 1; p_ar = 1; p_q1_en = 1; p_q1 = 1; p_q2_en = 1; p_q2 = 1;
        cyc(); bus.a_valid = 1; bus.a_rd = 12; bus.a_data = 32'hC;
        #1 rst_n = 0;
        p_ar_en = 1; p_ar = 0; p_we_en = 1; p_we = 0; p_wa_en = 1; p_wa = 0;
        p_wd_en = 1; p_wd = 0; p_q1_en = 1; p_q1 = 0; p_q2_en = 1; p_q2 = 0;
        cyc(); rst_n = 1;
        bus.a_valid = 1; bus.a_rd = 6; bus.a_data = 32'h66;
        p_ar_en = 1; p_ar = 1; p_q1_en = 1; p_q1 = 0;
        cyc(); idle(); pin_write(5'd6, 32'h66); p_q2_en = 1; p_q2 = 0;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
